array_hs: RTL and testbench

Parametrised successor of the testbench memory model: an N-word, DW-bit single-port array behind a valid/ready request handshake, with configurable read latency, a selectable backpressure pattern and out-of-range detection. It is instantiated only in testbenches, where it acts as the memory seen by generated designs, to exercise their handshake and latency tolerance. Every accepted request gets exactly one response, in order.

---
 rtl/array_hs.sv | 117 +++++++++++
 tb/tb_array_hs.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_hs.sv
// array_hs: N-word memory model behind a valid/ready request port. It has a configurable
// read latency, a selectable ready pattern and sticky out-of-range detection.
module array_hs #(
    parameter int         N          = 16,
    parameter int         AW         = 4,
    parameter int         DW         = 32,
    parameter int         LATENCY    = 1,
    parameter int         STALL_MODE = 1,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         INIT_MODE  = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] di_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] do_o,
    output logic          out_valid_o,
    output logic          err_o,
    output logic [15:0]   count_o
);
    localparam logic [AW:0] N_LIM = (AW+1)'(N);

    typedef logic [N-1:0][DW-1:0] mem_t;

    function automatic mem_t init_contents();
        mem_t m;
        for (int i = 0; i < N; i++) begin
            m[i] = (INIT_MODE == 0) ? DW'(i) : '0;
        end
        return m;
    endfunction

    // Contents exist only from time zero; reset deliberately leaves them alone.
    mem_t mem_q = init_contents();

    logic          ready_q, ready_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          err_q;
    logic [15:0]   count_q, count_d;
    logic          in_range;
    logic          accept;
    logic [DW-1:0] rd_data;

    logic [LATENCY-1:0] pv_q;
    logic [DW-1:0]      pd_q [LATENCY];

    assign in_range = ({1'b0, addr_i} < N_LIM);
    assign accept   = valid_i && ready_q && !rst_i;
    assign rd_data  = in_range ? mem_q[addr_i] : '0;
    assign count_d  = count_q + 16'd1;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (STALL_MODE == 0) begin
            ready_d = 1'b1;
        end else if (STALL_MODE == 1) begin
            ready_d = !ready_q;
        end else begin
            ready_d = lfsr_q[0];
        end
    end

    // Read-first: rd_data was sampled from the pre-edge contents above.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            mem_q[addr_i] <= di_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            lfsr_q  <= SEED;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ready_q <= ready_d;
            lfsr_q  <= lfsr_d;
            if (accept) begin
                count_q <= count_d;
                if (!in_range) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Data stages load only behind a valid bit, so the last stage holds the previous response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pv_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
            pv_q[0] <= accept;
            if (accept) begin
                pd_q[0] <= rd_data;
            end
        end
    end

    assign ready_o     = ready_q;
    assign out_valid_o = pv_q[LATENCY-1];
    assign do_o        = pd_q[LATENCY-1];
    assign err_o       = err_q;
    assign count_o     = count_q;
endmodule

// File: tb/tb_array_hs.sv
// Bench for array_hs: three configurations driven one at a time.
// The reference model tracks contents, ready pattern and due times of responses.
module tb_array_hs;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk;
    logic        rst       [3];
    logic        we        [3];
    logic        valid     [3];
    logic [3:0]  addr      [3];
    logic [31:0] di        [3];
    logic        rdy       [3];
    logic        ov        [3];
    logic        err       [3];
    logic [31:0] dout      [3];
    logic [15:0] cnt       [3];

    int p_n    [3] = '{16, 12, 16};
    int p_l    [3] = '{1, 3, 4};
    int p_mode [3] = '{0, 1, 2};
    int p_init [3] = '{0, 0, 1};

    array_hs #(.N(16), .AW(4), .DW(32), .LATENCY(1), .STALL_MODE(0), .SEED(SEED), .INIT_MODE(0)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .addr_i(addr[0]), .we_i(we[0]), .di_i(di[0]),
        .valid_i(valid[0]), .ready_o(rdy[0]), .do_o(dout[0]), .out_valid_o(ov[0]),
        .err_o(err[0]), .count_o(cnt[0]));

    array_hs #(.N(12), .AW(4), .DW(32), .LATENCY(3), .STALL_MODE(1), .SEED(SEED), .INIT_MODE(0)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .addr_i(addr[1]), .we_i(we[1]), .di_i(di[1]),
        .valid_i(valid[1]), .ready_o(rdy[1]), .do_o(dout[1]), .out_valid_o(ov[1]),
        .err_o(err[1]), .count_o(cnt[1]));

    array_hs #(.N(16), .AW(4), .DW(32), .LATENCY(4), .STALL_MODE(2), .SEED(SEED), .INIT_MODE(1)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .addr_i(addr[2]), .we_i(we[2]), .di_i(di[2]),
        .valid_i(valid[2]), .ready_o(rdy[2]), .do_o(dout[2]), .out_valid_o(ov[2]),
        .err_o(err[2]), .count_o(cnt[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic [31:0] ref_mem [3][16];
    resp_t       pend [$];
    logic [31:0] got  [$];
    bit          exp_ready;
    bit          exp_err;
    logic [15:0] exp_count;
    logic [7:0]  lfsr_m;
    logic [31:0] last_do;
    int          edge_no;

    int n_cmp;
    int n_fail;

    function automatic logic [7:0] next_lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
    task automatic step(input int k, input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input bit show, output logic acc);
        logic [31:0] rd;
        resp_t       r;
        bit          exp_ov;
        valid[k] = v;
        we[k]    = w;
        addr[k]  = a;
        di[k]    = d;
        acc      = v && exp_ready;
        @(posedge clk);
        edge_no++;
        if (acc) begin
            rd = (int'(a) < p_n[k]) ? ref_mem[k][a] : 32'h0;
            if (int'(a) >= p_n[k]) exp_err = 1'b1;
            else if (w) ref_mem[k][a] = d;
            exp_count = exp_count + 16'd1;
            r.due  = edge_no + p_l[k] - 1;
            r.data = rd;
            pend.push_back(r);
        end
        if (p_mode[k] == 0) begin
            exp_ready = 1'b1;
        end else if (p_mode[k] == 1) begin
            exp_ready = !exp_ready;
        end else begin
            exp_ready = lfsr_m[0];
            lfsr_m    = next_lfsr(lfsr_m);
        end
        @(negedge clk);
        exp_ov = (pend.size() > 0) && (pend[0].due == edge_no);
        if (exp_ov) begin
            last_do = pend[0].data;
            void'(pend.pop_front());
        end
        if (ov[k] === 1'b1) got.push_back(dout[k]);
        chk("out_valid", 32'(ov[k]), 32'(exp_ov));
        chk("do", dout[k], last_do);
        chk("ready", 32'(rdy[k]), 32'(exp_ready));
        chk("count", 32'(cnt[k]), 32'(exp_count));
        chk("err", 32'(err[k]), 32'(exp_err));
        if (show)
            $display("[%0t] inst%0d v=%0b we=%0b addr=%0d di=%h acc=%0b -> ov=%0b do=%h cnt=%0d err=%0b",
                     $time, k, v, w, a, d, acc, ov[k], dout[k], cnt[k], err[k]);
    endtask

    task automatic do_reset(input int k, input logic v, input logic w, input logic [3:0] a,
                            input logic [31:0] d);
        rst[k]   = 1'b1;
        valid[k] = v;
        we[k]    = w;
        addr[k]  = a;
        di[k]    = d;
        @(posedge clk);
        edge_no++;
        pend.delete();
        got.delete();
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_count = '0;
        lfsr_m    = SEED;
        last_do   = '0;
        @(negedge clk);
        rst[k]   = 1'b0;
        valid[k] = 1'b0;
        we[k]    = 1'b0;
        chk("rst_ready", 32'(rdy[k]), 32'd0);
        chk("rst_out_valid", 32'(ov[k]), 32'd0);
        chk("rst_do", dout[k], 32'd0);
        chk("rst_count", 32'(cnt[k]), 32'd0);
        chk("rst_err", 32'(err[k]), 32'd0);
        $display("[%0t] inst%0d reset (valid=%0b we=%0b during reset)", $time, k, v, w);
    endtask

    // Holds the request until the model says it was accepted, within a bounded number of cycles.
    task automatic req(input int k, input logic w, input logic [3:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) begin
            step(k, 1'b1, w, a, d, 1'b1, acc);
        end
        chk("req_accepted", 32'(acc), 32'd1);
        valid[k] = 1'b0;
        we[k]    = 1'b0;
    endtask

    task automatic drain(input int k, input int cycles);
        logic acc;
        for (int t = 0; t < cycles; t++) step(k, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, acc);
    endtask

    task automatic random_run(input int k, input int cycles);
        logic acc;
        for (int t = 0; t < cycles; t++) begin
            step(k, $urandom_range(3) != 0, 1'($urandom_range(1)), 4'($urandom_range(15)),
                 $urandom, 1'b0, acc);
        end
    endtask

    typedef struct {
        logic        v;
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic        exp_ov;
        logic [31:0] exp_do;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 5ms", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   n_acc;
        int   ones;

        n_cmp  = 0;
        n_fail = 0;
        edge_no = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) ref_mem[k][i] = (p_init[k] == 0 && i < p_n[k]) ? 32'(i) : 32'h0;
        end

        // Mode 0, latency 1: first row lands in the post-reset ready=0 cycle.
        tbl[0] = '{v: 1'b1, w: 1'b0, a: 4'd9, d: 32'h0, exp_ov: 1'b0, exp_do: 32'h0, exp_cnt: 16'd0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{v: 1'b1, w: 1'b0, a: 4'(i - 1), d: 32'h0, exp_ov: 1'b1,
                       exp_do: 32'(i - 1), exp_cnt: 16'(i)};
        tbl[17] = '{v: 1'b1, w: 1'b1, a: 4'd7,  d: 32'h1234,     exp_ov: 1'b1, exp_do: 32'd7,        exp_cnt: 16'd17};
        tbl[18] = '{v: 1'b1, w: 1'b0, a: 4'd7,  d: 32'h0,        exp_ov: 1'b1, exp_do: 32'h1234,     exp_cnt: 16'd18};
        tbl[19] = '{v: 1'b0, w: 1'b0, a: 4'd7,  d: 32'h0,        exp_ov: 1'b0, exp_do: 32'h1234,     exp_cnt: 16'd18};
        tbl[20] = '{v: 1'b1, w: 1'b1, a: 4'd15, d: 32'hCAFEF00D, exp_ov: 1'b1, exp_do: 32'd15,       exp_cnt: 16'd19};
        tbl[21] = '{v: 1'b1, w: 1'b0, a: 4'd15, d: 32'h0,        exp_ov: 1'b1, exp_do: 32'hCAFEF00D, exp_cnt: 16'd20};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; di[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // ---- instance A: table vectors ----
        do_reset(0, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 22; i++) begin
            step(0, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, 1'b1, acc);
            chk($sformatf("tbl%0d_ov", i), 32'(ov[0]), 32'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_do", i), dout[0], tbl[i].exp_do);
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt[0]), 32'(tbl[i].exp_cnt));
        end
        random_run(0, 150);

        // ---- instance A: counter wrap after 65537 acceptances ----
        do_reset(0, 1'b0, 1'b0, 4'd0, 32'd0);
        n_acc = 0;
        for (int t = 0; t < 70000 && n_acc < 65537; t++) begin
            step(0, 1'b1, 1'b0, 4'(t), 32'd0, 1'b0, acc);
            if (acc) n_acc++;
            if (acc && n_acc == 65535) chk("count_ffff", 32'(cnt[0]), 32'h0000FFFF);
        end
        chk("wrap_accepts", 32'(n_acc), 32'd65537);
        chk("count_wrap", 32'(cnt[0]), 32'd1);

        // ---- instance B: toggle ready, latency 3, write then read ----
        do_reset(1, 1'b0, 1'b0, 4'd0, 32'd0);
        req(1, 1'b1, 4'd5, 32'hDEAD);
        req(1, 1'b0, 4'd5, 32'h0);
        drain(1, 4);
        chk("b_resp_n", 32'(got.size()), 32'd2);
        chk("b_write_resp", got[0], 32'd5);
        chk("b_read_resp", got[1], 32'hDEAD);

        // ---- instance B: out of range (N=12) ----
        got.delete();
        req(1, 1'b1, 4'd13, 32'h55);
        req(1, 1'b0, 4'd13, 32'h0);
        req(1, 1'b0, 4'd12, 32'h0);
        req(1, 1'b0, 4'd11, 32'h0);
        req(1, 1'b0, 4'd1, 32'h0);
        drain(1, 4);
        chk("oor_resp_n", 32'(got.size()), 32'd5);
        chk("oor_write_resp", got[0], 32'd0);
        chk("oor_read13", got[1], 32'd0);
        chk("oor_read12", got[2], 32'd0);
        chk("oor_read11", got[3], 32'd11);
        chk("oor_read1", got[4], 32'd1);
        chk("oor_err_sticky", 32'(err[1]), 32'd1);
        random_run(1, 250);

        // ---- instance C: LFSR ready trace with valid held for 64 cycles ----
        do_reset(2, 1'b0, 1'b0, 4'd0, 32'd0);
        ones = 0;
        for (int t = 0; t < 64; t++) begin
            if (exp_ready) ones++;
            step(2, 1'b1, 1'b0, 4'($urandom_range(15)), 32'd0, 1'b0, acc);
        end
        chk("lfsr_count", 32'(cnt[2]), 32'(ones));
        random_run(2, 300);

        // ---- instance C: reset with reads in flight; valid+write held during reset ----
        do_reset(2, 1'b0, 1'b0, 4'd0, 32'd0);
        req(2, 1'b0, 4'd3, 32'h0);
        req(2, 1'b0, 4'd4, 32'h0);
        req(2, 1'b0, 4'd2, 32'h0);
        do_reset(2, 1'b1, 1'b1, 4'd2, 32'hBAD0BAD0);
        drain(2, 8);
        chk("flushed_resp_n", 32'(got.size()), 32'd0);
        req(2, 1'b0, 4'd2, 32'h0);
        drain(2, 5);
        chk("after_rst_read_n", 32'(got.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
